// File: rtl/hart_slice_arbiter_pkg.sv
// Shared definitions for the time-slicing hart arbiter: FSM state encoding
// and the selector-width helper.
package hart_slice_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_RUN    = 2'd0,
    ARB_DRAIN  = 2'd1,
    ARB_SETTLE = 2'd2
  } arb_state_e;

  // A single hart still needs a one-bit selector.
  function automatic int sel_width(input int n_harts);
    return (n_harts > 1) ? $clog2(n_harts) : 1;
  endfunction

endpackage

// File: rtl/hart_slice_arbiter_rr_pick.sv
// Combinational round-robin search: first set bit of i_req at or above
// i_start, wrapping around to bit 0.
module rr_pick
  import hart_slice_arbiter_pkg::*;
#(
  parameter int N_HARTS = 2,
  parameter int SEL_W   = sel_width(N_HARTS)
) (
  input  logic [N_HARTS-1:0] i_req,
  input  logic [SEL_W-1:0]   i_start,
  output logic [SEL_W-1:0]   o_idx,
  output logic               o_valid
);

  localparam int NP = 1 << SEL_W;

  always_comb begin
    logic [NP-1:0] req_pad;
    int            pos;
    req_pad = NP'(i_req);
    o_idx   = '0;
    o_valid = 1'b0;
    pos     = 0;
    // Walk from the farthest offset down so the nearest hit is written last.
    for (int i = N_HARTS - 1; i >= 0; i--) begin
      pos = int'(i_start) + i;
      if (pos >= N_HARTS) pos = pos - N_HARTS;
      if (req_pad[SEL_W'(pos)]) begin
        o_idx   = SEL_W'(pos);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hart_slice_arbiter.sv
// Quantum-based hart scheduler: skips non-runnable harts, prefers harts with
// pending interrupts, drains to a safe point before switching.
module hart_slice_arbiter
  import hart_slice_arbiter_pkg::*;
#(
  parameter int N_HARTS = 2,
  parameter int QW      = 8,
  parameter int SEL_W   = sel_width(N_HARTS)
) (
  input  logic               CLK,
  input  logic               RST_X,
  input  logic               i_hold,
  input  logic               i_mmu_busy,
  input  logic [N_HARTS-1:0] i_safe,
  input  logic [N_HARTS-1:0] i_runnable,
  input  logic [N_HARTS-1:0] i_irq,
  input  logic [N_HARTS-1:0] i_retire,
  input  logic [QW-1:0]      i_quantum,
  input  logic [N_HARTS-1:0] i_flush_req,
  output logic [SEL_W-1:0]   o_sel,
  output logic [N_HARTS-1:0] o_sel_oh,
  output logic               o_switch,
  output logic               o_flush_all,
  output logic [QW-1:0]      o_left
);

  arb_state_e         state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [N_HARTS-1:0] sel_oh_q, sel_oh_d;
  logic               switch_q, switch_d;
  logic               flush_q, flush_d;
  logic [QW-1:0]      left_q, left_d;
  logic               init_q, init_d;

  logic [N_HARTS-1:0] cand, irq_cand;
  logic [SEL_W-1:0]   start, irq_idx, any_idx, next_sel;
  logic               irq_vld, any_vld;
  logic               sel_runnable, sel_irq, sel_safe, sel_retire;
  logic               expired, want, gate_ok;

  assign cand     = (i_runnable | i_irq) & ~sel_oh_q;
  assign irq_cand = i_irq & cand;
  assign start    = (int'(sel_q) >= N_HARTS - 1) ? '0 : sel_q + SEL_W'(1);

  rr_pick #(.N_HARTS(N_HARTS), .SEL_W(SEL_W)) u_pick_irq (
    .i_req   (irq_cand),
    .i_start (start),
    .o_idx   (irq_idx),
    .o_valid (irq_vld)
  );

  rr_pick #(.N_HARTS(N_HARTS), .SEL_W(SEL_W)) u_pick_any (
    .i_req   (cand),
    .i_start (start),
    .o_idx   (any_idx),
    .o_valid (any_vld)
  );

  assign next_sel     = irq_vld ? irq_idx : any_idx;
  assign sel_runnable = |(i_runnable & sel_oh_q);
  assign sel_irq      = |(i_irq & sel_oh_q);
  assign sel_safe     = |(i_safe & sel_oh_q);
  assign sel_retire   = |(i_retire & sel_oh_q);

  // The zero counter left by reset is not an expiry; it is reloaded first.
  assign expired = (left_q == '0) && (i_quantum != '0) && !init_q;
  assign want    = any_vld &&
                   (expired || (!sel_runnable && !sel_irq) || (!sel_irq && irq_vld));
  assign gate_ok = sel_safe && !i_hold && !i_mmu_busy && !(|i_flush_req) && !flush_q;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    left_d  = left_q;
    init_d  = 1'b0;
    flush_d = |i_flush_req;
    case (state_q)
      ARB_RUN: begin
        if (init_q || (left_q == '0 && !any_vld)) begin
          left_d = i_quantum;
        end else if (sel_retire && left_q != '0) begin
          left_d = left_q - QW'(1);
        end
        if (want) state_d = ARB_DRAIN;
      end
      ARB_DRAIN: begin
        if (!any_vld) begin
          state_d = ARB_RUN;
        end else if (gate_ok) begin
          state_d = ARB_SETTLE;
          sel_d   = next_sel;
          left_d  = i_quantum;
        end
      end
      ARB_SETTLE: state_d = ARB_RUN;
      default:    state_d = ARB_RUN;
    endcase
    sel_oh_d = N_HARTS'(1) << sel_d;
    switch_d = (state_d == ARB_SETTLE);
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q  <= ARB_RUN;
      sel_q    <= '0;
      sel_oh_q <= N_HARTS'(1);
      switch_q <= 1'b0;
      flush_q  <= 1'b0;
      left_q   <= '0;
      init_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      sel_oh_q <= sel_oh_d;
      switch_q <= switch_d;
      flush_q  <= flush_d;
      left_q   <= left_d;
      init_q   <= init_d;
    end
  end

  assign o_sel       = sel_q;
  assign o_sel_oh    = sel_oh_q;
  assign o_switch    = switch_q;
  assign o_flush_all = flush_q;
  assign o_left      = left_q;

endmodule

// File: doc/hart_slice_arbiter.md
# hart_slice_arbiter

Time-slicing hart arbiter for the multi-hart RV cluster. It owns the shared-port hart selector that drives the cluster's address, data and MMU muxes. It generalises a plain "advance on safe point" round-robin into a quantum-based scheduler with three extra behaviours: it skips harts that are not runnable, gives priority to harts with a pending interrupt, and drains to a safe point before every switch. It also registers and broadcasts the cluster-wide TLB flush.

## Interface
- `N_HARTS`, default 2: number of harts, 1..16.
- `QW`, default 8: width of the quantum and retire counter.
- `SEL_W`, default `$clog2(N_HARTS)` (1 when `N_HARTS`==1): selector width.
- `CLK` in 1: clock.
- `RST_X` in 1: reset, asynchronous, active-low.
- `i_hold` in 1: global hold. High when the cluster is not in CPU mode or the next mode is MC.
- `i_mmu_busy` in 1: shared MMU has a walk or a pagefault outstanding.
- `i_safe` in `N_HARTS`: per-hart safe point. Means next_state idle, interrupt ok, branch taken resolved, no exception, no CSR or TLB flush.
- `i_runnable` in `N_HARTS`: hart is not halted and not in WFI.
- `i_irq` in `N_HARTS`: hart has a pending, enabled interrupt.
- `i_retire` in `N_HARTS`: one-cycle pulse per retired instruction.
- `i_quantum` in `QW`: slice length in retired instructions. 0 disables quantum expiry.
- `i_flush_req` in `N_HARTS`: per-hart TLB flush request.
- `o_sel` out `SEL_W`: selected hart.
- `o_sel_oh` out `N_HARTS`: one-hot form of `o_sel`.
- `o_switch` out 1: high during the SETTLE cycle only.
- `o_flush_all` out 1: registered OR of `i_flush_req`.
- `o_left` out `QW`: instructions remaining in the current slice.

## Operation
- States:
  - RUN: counting retires of the selected hart.
  - DRAIN: a switch is wanted; waiting for a safe point.
  - SETTLE: one cycle for the new hart's addresses to propagate.
- Candidate set: `C = (i_runnable | i_irq) & ~o_sel_oh`.
- Next hart:
  - If `i_irq & C` is nonzero, take the first set bit of `i_irq & C`, searching upward from `o_sel+1` with wrap.
  - Otherwise take the first set bit of `C`, with the same search.
- Switch wanted in RUN when `C != 0` and any of these holds:
  - `o_left == 0` with `i_quantum != 0`;
  - `!i_runnable[o_sel] && !i_irq[o_sel]`;
  - `!i_irq[o_sel] && |(i_irq & C)`.
- RUN→DRAIN when a switch is wanted.
- DRAIN→SETTLE when `i_safe[o_sel] && !i_hold && !i_mmu_busy && !|i_flush_req && !o_flush_all`. On this edge:
  - `o_sel` loads the next hart, re-evaluated in this cycle;
  - `o_left` loads `i_quantum`.
- DRAIN→RUN without switching if `C` becomes 0. The counter is untouched.
- SETTLE→RUN unconditionally. No switch is evaluated in SETTLE.
- Counter:
  - in RUN, `i_retire[o_sel]` decrements `o_left`, saturating at 0;
  - retires from non-selected harts are ignored;
  - when `o_left == 0` and `C == 0`, `o_left` reloads `i_quantum` on the next cycle and the same hart continues.
- `N_HARTS==1`: `C` is always 0, so the block never leaves RUN.
- The quantum is sampled only at reload. Changing `i_quantum` mid-slice has no effect on the current slice.

## Timing
- Reset values, all asynchronous:
  - state RUN;
  - `o_sel` 0;
  - `o_sel_oh` = 1;
  - `o_switch` 0;
  - `o_flush_all` 0;
  - `o_left` 0, reloaded from `i_quantum` one cycle after reset release.
- Minimum switch latency: the decision cycle (RUN→DRAIN) plus one DRAIN cycle. `o_sel` changes on the DRAIN→SETTLE edge, two edges after the trigger.
- `o_switch` is high for exactly one cycle per switch, aligned with the first cycle of the new `o_sel`.
- `o_flush_all` is `|i_flush_req` delayed by one cycle. It is independent of state and never dropped.
- Simultaneous flush and safe point: the switch is deferred until both `i_flush_req` and `o_flush_all` are low.
- Reset asserted mid-DRAIN or mid-SETTLE returns to the reset values immediately. Reset is not glitch-gated.
- All outputs are registered. No combinational path from any input to any output.

## Structure
- A shared cluster package holds:
  - the state encoding constants `ARB_RUN`, `ARB_DRAIN`, `ARB_SETTLE`;
  - the `SEL_W` computation function.
- Sub-module `rr_pick`: a combinational round-robin first-set-bit search, parameterised by `N_HARTS`. Inputs: request vector and start index. Outputs: index and valid. Instantiate it twice, once for irq candidates and once for all candidates.

## Test plan
- `N_HARTS`=2, `i_quantum`=4, all runnable, `i_safe`=all ones, `i_retire[0]` every cycle → after 4 retires `o_sel` goes 0→1 two edges later with `o_switch`=1 for one cycle, and `o_left`=4.
- `N_HARTS`=4, hart 1 selected, `i_runnable`=4'b1001 → switches to hart 3, skipping hart 2. A later switch wraps to hart 0.
- `N_HARTS`=4, hart 0 selected, `i_irq`=4'b0100, quantum not expired → switches to hart 2 ahead of hart 1.
- Switch pending with `i_safe[o_sel]`=0 for 10 cycles, `i_mmu_busy` pulsed, and `i_flush_req`=2'b10 for one cycle → `o_flush_all` high exactly one cycle later, and `o_sel` changes only in the first cycle where all gating conditions are clear.
- `i_quantum`=0, all runnable → `o_sel` never changes. Then drop `i_runnable[o_sel]` → switch occurs.
- Assert `RST_X`=0 during DRAIN → `o_sel`=0, `o_switch`=0 and `o_flush_all`=0 with no clock edge. After release, normal round-robin resumes from hart 0.
